serial_work_rx: RTL and testbench
=================================

SERIAL_WORK_RX -- requirements
Module: serial_work_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 100, meaning clock cycles per UART bit (50 MHz clock, 500 kbps).
REQ-002 SHALL have parameter TIMEOUT_BITS, default 64, meaning idle bit-times after which a partial work message is discarded.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port RxD, input, 1 bit: asynchronous serial line, idle high.
REQ-006 SHALL have port midstate, output, 256 bits: last complete midstate.
REQ-007 SHALL have port data, output, 96 bits: last complete data tail.
REQ-008 SHALL have port work_valid, output, 1 bit: one-cycle pulse when midstate/data update.
REQ-009 SHALL have port frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port busy, output, 1 bit: high while a message is partially assembled.

Function
REQ-011 SHALL pass RxD through a 2-flop synchronizer before any use; the synchronizer resets to 1.
REQ-012 SHALL run a receiver FSM with states IDLE, START, DATA, STOP.
REQ-013 IDLE -> START SHALL occur on a synchronized falling level (0).
REQ-014 START SHALL re-sample the line at CLKS_PER_BIT/2 cycles: 0 -> DATA; 1 -> IDLE (glitch, nothing recorded).
REQ-015 DATA SHALL sample 8 bits, LSB first, each CLKS_PER_BIT cycles after the previous sample.
REQ-016 STOP SHALL sample CLKS_PER_BIT cycles after bit 7: 1 -> byte accepted; 0 -> frame_err pulse, byte dropped, byte counter cleared, FSM to IDLE.
REQ-017 Accepted bytes SHALL shift into a 352-bit assembly register from the LSB end; the first byte of a message ends in bits [351:344].
REQ-018 A 6-bit byte counter SHALL count 0..43.
REQ-019 On the 44th accepted byte, on the same edge, midstate SHALL take assembly[351:96] and data SHALL take assembly[95:0] including the new byte, work_valid SHALL pulse on the following cycle, and the counter SHALL return to 0.
REQ-020 midstate and data SHALL change only on that edge (atomic update) and SHALL hold otherwise.
REQ-021 busy SHALL equal (counter != 0).
REQ-022 An idle counter SHALL reset on every accepted byte and advance only while busy and the FSM is in IDLE.
REQ-023 When the idle counter reaches TIMEOUT_BITS*CLKS_PER_BIT, the byte counter SHALL clear, with no pulse and no output change.
REQ-024 When a timeout and a start edge fall on the same cycle, the timeout SHALL win first; the new byte then begins message byte 0.
REQ-025 Back-to-back frames (next start immediately after the stop sample) SHALL be received without loss.

Reset
REQ-026 On rst_n low, the FSM SHALL go to IDLE and all counters to 0.
REQ-027 On rst_n low, the assembly register, midstate and data SHALL go to 0.
REQ-028 On rst_n low, work_valid and frame_err SHALL go to 0 and busy SHALL read 0.
REQ-029 A reset mid-byte or mid-message SHALL discard all partial state; reception SHALL restart at the next start bit after release.

Structure
REQ-030 A shared package SHALL hold MSG_BYTES=44, MIDSTATE_W=256, DATA_W=96 and the FSM state enum.
REQ-031 The byte receiver (synchronizer + FSM, outputs byte + strobe + frame_err) SHALL be sub-module uart_rx_byte; assembly, timeout and outputs stay in serial_work_rx.

Verification
REQ-032 Scenario: 44 bytes 85 a2 43 91 ... 8b 3f 07 ef c5 13 05 1a 02 a9 90 50 bf ec 03 73 at 100 clk/bit, start at cycle 200 -> one work_valid, midstate=85a24391639705f42f64b3b688df3d147445123c323e62143d87e1908b3f07ef, data=c513051a02a99050bfec0373.
REQ-033 Scenario: 20 bytes, line idle 6400 cycles, then the full 44 bytes -> no pulse after the 20 bytes, busy drops at timeout, final outputs as in REQ-032.
REQ-034 Scenario: byte 10 sent with stop bit 0 -> frame_err pulse, busy=0, outputs unchanged, the next full 44 bytes load correctly.
REQ-035 Scenario: 30-cycle low glitch on an idle line -> no byte accepted, counter stays 0.
REQ-036 Scenario: rst_n low during byte 43 of a message, then the full message -> all outputs 0 after reset, a single correct load afterwards.
REQ-037 Scenario: two messages back-to-back with a different first byte (0x11) -> two work_valid pulses exactly 44*10*100 cycles apart, and midstate[255:248]=0x11 after the second.

Source files
------------

// File: rtl/serial_work_rx_pkg.sv
// Shared constants and receiver state type for the serial work-message receiver.
package serial_work_rx_pkg;

  localparam int MSG_BYTES  = 44;
  localparam int MIDSTATE_W = 256;
  localparam int DATA_W     = 96;
  localparam int ASM_W      = MIDSTATE_W + DATA_W;
  localparam int BYTE_CNT_W = 6;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/serial_work_rx_uart_rx.sv
// 8N1 byte receiver: 2-flop synchronizer plus a mid-bit sampling FSM.
// state    | meaning
// RX_IDLE  | line idle, waiting for a synchronized low level
// RX_START | half a bit into the start bit, confirm it is still low
// RX_DATA  | sampling 8 data bits LSB first, one per bit time
// RX_STOP  | sampling the stop bit; high accepts the byte, low flags a frame error
module uart_rx_byte
  import serial_work_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd,
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       frame_err,
  output rx_state_t  state
);

  localparam int TMR_W = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TMR_W-1:0] BIT_LOAD  = TMR_W'(CLKS_PER_BIT - 1);

  logic             rxd_meta;
  logic             rxd_sync;
  logic [TMR_W-1:0] timer;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             timer_done;

  assign timer_done = (timer == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_sync <= rxd_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RX_IDLE;
      timer     <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      rx_byte   <= '0;
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_strobe <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (!rxd_sync) begin
            state <= RX_START;
            timer <= HALF_LOAD;
          end
        end
        RX_START: begin
          if (!timer_done) begin
            timer <= timer - 1'b1;
          end else if (!rxd_sync) begin
            state   <= RX_DATA;
            timer   <= BIT_LOAD;
            bit_idx <= '0;
          end else begin
            state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (!timer_done) begin
            timer <= timer - 1'b1;
          end else begin
            shift <= {rxd_sync, shift[7:1]};
            timer <= BIT_LOAD;
            if (bit_idx == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (!timer_done) begin
            timer <= timer - 1'b1;
          end else begin
            state <= RX_IDLE;
            if (rxd_sync) begin
              rx_byte   <= shift;
              rx_strobe <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/serial_work_rx.sv
// Assembles 44 received bytes into a 256-bit midstate and 96-bit data tail,
// discarding partial messages after a line-idle timeout or a framing error.
module serial_work_rx
  import serial_work_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 100,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RxD,
  output logic [MIDSTATE_W-1:0] midstate,
  output logic [DATA_W-1:0]     data,
  output logic                  work_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int TIMEOUT_CLKS = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [IDLE_W-1:0]     IDLE_LOAD = IDLE_W'(TIMEOUT_CLKS - 1);
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(MSG_BYTES - 1);

  logic [7:0]            rx_byte;
  logic                  rx_strobe;
  logic                  rx_ferr;
  rx_state_t             rx_state;
  logic [ASM_W-1:0]      assembly;
  logic [ASM_W-1:0]      asm_next;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic [IDLE_W-1:0]     idle_tmr;
  logic                  timeout;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (RxD),
    .rx_byte   (rx_byte),
    .rx_strobe (rx_strobe),
    .frame_err (rx_ferr),
    .state     (rx_state)
  );

  assign frame_err = rx_ferr;
  assign busy      = (byte_cnt != '0);
  assign asm_next  = {assembly[ASM_W-9:0], rx_byte};
  assign timeout   = busy && (rx_state == RX_IDLE) && (idle_tmr == '0);

  // Idle timer only runs between frames of a partial message.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_tmr <= IDLE_LOAD;
    end else if (rx_strobe || !busy || timeout) begin
      idle_tmr <= IDLE_LOAD;
    end else if (rx_state == RX_IDLE) begin
      idle_tmr <= idle_tmr - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      assembly   <= '0;
      midstate   <= '0;
      data       <= '0;
      byte_cnt   <= '0;
      work_valid <= 1'b0;
    end else begin
      work_valid <= 1'b0;
      if (rx_strobe) begin
        assembly <= asm_next;
        if (byte_cnt == LAST_BYTE) begin
          midstate   <= asm_next[ASM_W-1:DATA_W];
          data       <= asm_next[DATA_W-1:0];
          work_valid <= 1'b1;
          byte_cnt   <= '0;
        end else begin
          byte_cnt <= byte_cnt + 1'b1;
        end
      end else if (rx_ferr || timeout) begin
        byte_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_serial_work_rx.sv
// Self-checking bench for serial_work_rx with randomized work messages.
module tb_serial_work_rx;

  localparam int CPB = 10;
  localparam int TOB = 64;
  localparam int NB  = 44;
  localparam int FRAME_CLKS = 10 * CPB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         RxD = 1'b1;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic         work_valid;
  logic         frame_err;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wv_cnt = 0;
  int wv_last = 0;
  int wv_prev = 0;
  int fe_cnt = 0;

  logic [7:0]   msg [NB];
  logic [351:0] spec_vec;

  serial_work_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RxD        (RxD),
    .midstate   (midstate),
    .data       (data),
    .work_valid (work_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (work_valid) begin
      wv_cnt  = wv_cnt + 1;
      wv_prev = wv_last;
      wv_last = cyc;
    end
    if (frame_err) fe_cnt = fe_cnt + 1;
  end

  // Reference: message byte i occupies the i-th byte from the top of a 352-bit word.
  function automatic logic [351:0] model_vec();
    logic [351:0] v;
    v = '0;
    for (int i = 0; i < NB; i++) v[351 - 8*i -: 8] = msg[i];
    return v;
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      wait_cycles(CPB);
    end
    RxD = stop;
    wait_cycles(CPB);
    RxD = 1'b1;
  endtask

  task automatic send_msg(input int n);
    for (int i = 0; i < n; i++) send_byte(msg[i], 1'b1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < NB; i++) msg[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic fill_spec();
    for (int i = 0; i < NB; i++) msg[i] = spec_vec[351 - 8*i -: 8];
  endtask

  task automatic test_reset();
    RxD = 1'b1;
    rst_n = 1'b0;
    wait_cycles(5);
    rst_n = 1'b1;
    wait_cycles(3);
    checks++; if (midstate !== 256'd0) begin errors++; $display("FAIL reset_midstate got=%h exp=0", midstate); end
    checks++; if (data !== 96'd0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
    checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL reset_work_valid got=%b exp=0", work_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_known_message();
    int w0;
    logic [351:0] v;
    fill_spec();
    v = model_vec();
    w0 = wv_cnt;
    wait_cycles(20);
    send_msg(NB);
    wait_cycles(5);
    checks++; if (wv_cnt - w0 !== 1) begin errors++; $display("FAIL known_pulses got=%0d exp=1", wv_cnt - w0); end
    checks++; if (midstate !== v[351:96]) begin errors++; $display("FAIL known_midstate got=%h exp=%h", midstate, v[351:96]); end
    checks++; if (data !== v[95:0]) begin errors++; $display("FAIL known_data got=%h exp=%h", data, v[95:0]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL known_busy got=%b exp=0", busy); end
  endtask

  task automatic test_timeout();
    int w0;
    logic [255:0] m0;
    logic [95:0]  d0;
    logic [351:0] v;
    m0 = midstate;
    d0 = data;
    w0 = wv_cnt;
    fill_random();
    send_msg(20);
    wait_cycles(2);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_partial got=%b exp=1", busy); end
    checks++; if (wv_cnt - w0 !== 0) begin errors++; $display("FAIL timeout_no_pulse got=%0d exp=0", wv_cnt - w0); end
    wait_cycles(TOB*CPB - 2*CPB);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_before got=%b exp=1", busy); end
    wait_cycles(4*CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy_after got=%b exp=0", busy); end
    checks++; if (midstate !== m0 || data !== d0) begin errors++; $display("FAIL timeout_hold got=%h exp=%h", midstate, m0); end
    fill_spec();
    v = model_vec();
    send_msg(NB);
    wait_cycles(5);
    checks++; if (wv_cnt - w0 !== 1) begin errors++; $display("FAIL timeout_pulses got=%0d exp=1", wv_cnt - w0); end
    checks++; if (midstate !== v[351:96] || data !== v[95:0]) begin errors++; $display("FAIL timeout_load got=%h %h exp=%h", midstate, data, v); end
  endtask

  task automatic test_frame_err();
    int w0, f0;
    logic [255:0] m0;
    logic [351:0] v;
    m0 = midstate;
    w0 = wv_cnt;
    f0 = fe_cnt;
    fill_random();
    send_msg(10);
    send_byte(msg[10], 1'b0);
    wait_cycles(CPB);
    checks++; if (fe_cnt - f0 !== 1) begin errors++; $display("FAIL ferr_pulse got=%0d exp=1", fe_cnt - f0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ferr_busy got=%b exp=0", busy); end
    checks++; if (midstate !== m0) begin errors++; $display("FAIL ferr_hold got=%h exp=%h", midstate, m0); end
    fill_random();
    v = model_vec();
    send_msg(NB);
    wait_cycles(5);
    checks++; if (wv_cnt - w0 !== 1) begin errors++; $display("FAIL ferr_pulses got=%0d exp=1", wv_cnt - w0); end
    checks++; if (midstate !== v[351:96] || data !== v[95:0]) begin errors++; $display("FAIL ferr_load got=%h %h exp=%h", midstate, data, v); end
  endtask

  task automatic test_glitch();
    int w0, f0;
    w0 = wv_cnt;
    f0 = fe_cnt;
    RxD = 1'b0;
    wait_cycles(3);
    RxD = 1'b1;
    wait_cycles(3*CPB);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got=%b exp=0", busy); end
    checks++; if (fe_cnt - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got=%0d exp=0", fe_cnt - f0); end
    checks++; if (wv_cnt - w0 !== 0) begin errors++; $display("FAIL glitch_pulse got=%0d exp=0", wv_cnt - w0); end
  endtask

  task automatic test_reset_mid_message();
    int w0;
    logic [351:0] v;
    fill_random();
    send_msg(NB - 1);
    RxD = 1'b0;
    wait_cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      RxD = msg[NB-1][i];
      wait_cycles(CPB);
    end
    rst_n = 1'b0;
    RxD = 1'b1;
    wait_cycles(3);
    checks++; if (midstate !== 256'd0 || data !== 96'd0) begin errors++; $display("FAIL rstmid_outputs got=%h %h exp=0", midstate, data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    wait_cycles(2*CPB);
    w0 = wv_cnt;
    fill_random();
    v = model_vec();
    send_msg(NB);
    wait_cycles(5);
    checks++; if (wv_cnt - w0 !== 1) begin errors++; $display("FAIL rstmid_pulses got=%0d exp=1", wv_cnt - w0); end
    checks++; if (midstate !== v[351:96] || data !== v[95:0]) begin errors++; $display("FAIL rstmid_load got=%h %h exp=%h", midstate, data, v); end
  endtask

  task automatic test_back_to_back();
    int w0;
    logic [351:0] v;
    w0 = wv_cnt;
    fill_random();
    send_msg(NB);
    fill_random();
    msg[0] = 8'h11;
    v = model_vec();
    send_msg(NB);
    wait_cycles(5);
    checks++; if (wv_cnt - w0 !== 2) begin errors++; $display("FAIL b2b_pulses got=%0d exp=2", wv_cnt - w0); end
    checks++; if (wv_last - wv_prev !== NB*FRAME_CLKS) begin errors++; $display("FAIL b2b_spacing got=%0d exp=%0d", wv_last - wv_prev, NB*FRAME_CLKS); end
    checks++; if (midstate[255:248] !== 8'h11) begin errors++; $display("FAIL b2b_first_byte got=%h exp=11", midstate[255:248]); end
    checks++; if (midstate !== v[351:96] || data !== v[95:0]) begin errors++; $display("FAIL b2b_load got=%h %h exp=%h", midstate, data, v); end
  endtask

  initial begin
    spec_vec = {256'h85a24391639705f42f64b3b688df3d147445123c323e62143d87e1908b3f07ef,
                96'hc513051a02a99050bfec0373};
    test_reset();
    test_known_message();
    test_timeout();
    test_frame_err();
    test_glitch();
    test_reset_mid_message();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
